scan_index_gen: RTL

SCAN_INDEX_GEN -- requirements
Module: scan_index_gen

---
 rtl/scan_index_gen.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/scan_index_gen.sv
// scan_index_gen: circular channel scanner. It walks the enabled bits of
// chan_en, presents one 3-bit index at a time with a valid/ready handshake,
// and can insert a programmable dwell after each accepted index. Every output
// comes straight from a flop.
module scan_index_gen #(
   parameter int DWELL_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               stop,
   input  logic [7:0]         chan_en,
   input  logic [DWELL_W-1:0] dwell,
   output logic [2:0]         idx_out,
   output logic               idx_valid,
   input  logic               idx_ready,
   output logic               busy,
   output logic               wrap,
   output logic               empty_err
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SEEK,
      S_PRESENT,
      S_HOLD
   } state_t;

   state_t             state_q, state_d;
   logic [2:0]         idx_q, idx_d;
   logic [2:0]         last_q, last_d;
   logic [DWELL_W-1:0] cnt_q, cnt_d;
   logic               stop_pend_q, stop_pend_d;
   logic               valid_q, valid_d;
   logic               busy_q, busy_d;
   logic               wrap_q, wrap_d;
   logic               empty_q, empty_d;
   logic [2:0]         sel;

   // First enabled channel found walking upward from 'from', wrapping 7 -> 0.
   // When no bit is set the result is unused (callers check chan_en first).
   function automatic logic [2:0] next_index(input logic [7:0] en,
                                             input logic [2:0] from);
      logic [2:0] cand;
      logic       found;
      next_index = from;
      found      = 1'b0;
      for (int k = 0; k < 8; k++) begin
         cand = from + 3'(k);
         if (!found && en[cand]) begin
            next_index = cand;
            found      = 1'b1;
         end
      end
   endfunction

   assign sel       = next_index(chan_en, last_q + 3'd1);
   assign idx_out   = idx_q;
   assign idx_valid = valid_q;
   assign busy      = busy_q;
   assign wrap      = wrap_q;
   assign empty_err = empty_q;

   // Next-state, datapath and registered-output computation.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      last_d      = last_q;
      cnt_d       = cnt_q;
      stop_pend_d = stop_pend_q;
      wrap_d      = 1'b0;
      empty_d     = 1'b0;

      case (state_q)
         S_IDLE: begin
            // start together with stop is treated as no request at all
            if (start && !stop) begin
               if (chan_en != 8'h00) state_d = S_SEEK;
               else                  empty_d = 1'b1;
            end
         end
         S_SEEK: begin
            if (stop) begin
               state_d = S_IDLE;
            end else if (chan_en == 8'h00) begin
               state_d = S_IDLE;
               empty_d = 1'b1;
            end else begin
               idx_d   = sel;
               last_d  = sel;
               wrap_d  = (sel <= last_q);
               state_d = S_PRESENT;
            end
         end
         S_PRESENT: begin
            // A stop here must not strand the presented index, so remember it
            // and act on it once the transfer happens.
            stop_pend_d = stop_pend_q | stop;
            if (idx_ready) begin
               if (stop_pend_q || stop) begin
                  state_d = S_IDLE;
               end else if (dwell != '0) begin
                  cnt_d   = dwell;
                  state_d = S_HOLD;
               end else begin
                  state_d = S_SEEK;
               end
            end
         end
         S_HOLD: begin
            cnt_d = cnt_q - DWELL_W'(1);
            if (stop)                         state_d = S_IDLE;
            else if (cnt_q <= DWELL_W'(1))    state_d = S_SEEK;
         end
         default: state_d = S_IDLE;
      endcase

      // Every return to IDLE restarts the scan from channel 0 next time.
      if (state_d == S_IDLE && state_q != S_IDLE) begin
         stop_pend_d = 1'b0;
         last_d      = 3'd7;
         cnt_d       = '0;
      end

      valid_d = (state_d == S_PRESENT);
      busy_d  = (state_d != S_IDLE);
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         idx_q       <= 3'd0;
         last_q      <= 3'd7;
         cnt_q       <= '0;
         stop_pend_q <= 1'b0;
         valid_q     <= 1'b0;
         busy_q      <= 1'b0;
         wrap_q      <= 1'b0;
         empty_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         last_q      <= last_d;
         cnt_q       <= cnt_d;
         stop_pend_q <= stop_pend_d;
         valid_q     <= valid_d;
         busy_q      <= busy_d;
         wrap_q      <= wrap_d;
         empty_q     <= empty_d;
      end
   end

endmodule
